gray_dec_display: RTL

- Downstream stage of the Gray encoder: it captures the 4-bit Gray code that the encoder produces and converts it back to binary.
- It splits the 0–15 binary value into two decimal digits and drives a two-digit multiplexed 7-segment display.
- It closes the decimal→Gray→binary→decimal loop on the board and exposes the intermediate binary value for checking.

---
 rtl/gray_dec_display.sv | 115 +++++++++++
 1 files changed

// File: rtl/gray_dec_display.sv
// rtl/gray_dec_display.sv - Gray-to-binary decoder with two-digit multiplexed 7-segment display
module gray_dec_display #(
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] gray_in,
    input  logic       load,
    output logic [3:0] bin_out,
    output logic [3:0] dec_tens,
    output logic [3:0] dec_ones,
    output logic       valid,
    output logic [6:0] seg,
    output logic [1:0] an
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [3:0]    g_q, g_d;
    logic          s1_q, s1_d;
    logic [3:0]    bin_q, bin_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic          sel_q, sel_d;

    logic [3:0] b;
    logic       ge10;

    always_comb begin
        b[3] = g_q[3];
        b[2] = b[3] ^ g_q[2];
        b[1] = b[2] ^ g_q[1];
        b[0] = b[1] ^ g_q[0];
        ge10 = (b >= 4'd10);

        g_d    = load ? gray_in : g_q;
        s1_d   = load;
        bin_d  = bin_q;
        tens_d = tens_q;
        ones_d = ones_q;
        valid_d = s1_q;
        // Stage 2 only advances behind a capture, so load=0 holds the data
        if (s1_q) begin
            bin_d  = b;
            tens_d = {3'b000, ge10};
            ones_d = b - (ge10 ? 4'd10 : 4'd0);
        end

        refresh_cnt_d = refresh_cnt_q + 1'b1;
        sel_d         = sel_q;
        if (refresh_cnt_q == CNT_MAX) begin
            refresh_cnt_d = '0;
            sel_d         = ~sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q           <= '0;
            s1_q          <= 1'b0;
            bin_q         <= '0;
            tens_q        <= '0;
            ones_q        <= '0;
            valid_q       <= 1'b0;
            refresh_cnt_q <= '0;
            sel_q         <= 1'b0;
        end else begin
            g_q           <= g_d;
            s1_q          <= s1_d;
            bin_q         <= bin_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            valid_q       <= valid_d;
            refresh_cnt_q <= refresh_cnt_d;
            sel_q         <= sel_d;
        end
    end

    logic [3:0] digit;
    logic [6:0] seg_lo;
    logic [1:0] an_lo;

    // Display is driven straight from the digit registers so it tracks them on the same edge
    always_comb begin
        digit = sel_q ? tens_q : ones_q;
        case (digit)
            4'd0:    seg_lo = 7'b1000000;
            4'd1:    seg_lo = 7'b1111001;
            4'd2:    seg_lo = 7'b0100100;
            4'd3:    seg_lo = 7'b0110000;
            4'd4:    seg_lo = 7'b0011001;
            4'd5:    seg_lo = 7'b0010010;
            4'd6:    seg_lo = 7'b0000010;
            4'd7:    seg_lo = 7'b1111000;
            4'd8:    seg_lo = 7'b0000000;
            4'd9:    seg_lo = 7'b0010000;
            default: seg_lo = 7'b1111111;
        endcase
        an_lo = sel_q ? 2'b01 : 2'b10;
        if (sel_q && (tens_q == 4'd0)) begin
            an_lo  = 2'b11;
            seg_lo = 7'b1111111;
        end
    end

    assign bin_out  = bin_q;
    assign dec_tens = tens_q;
    assign dec_ones = ones_q;
    assign valid    = valid_q;
    assign seg      = SEG_ACTIVE_LOW ? seg_lo : ~seg_lo;
    assign an       = SEG_ACTIVE_LOW ? an_lo : ~an_lo;
endmodule
